// File: rtl/jt7759_parser.sv
// Command/sample parser for a uPD7759-style ADPCM player: walks the phrase table,
// decodes sample commands and paces ADPCM nibbles out to the decoder.
module jt7759_parser #(
  parameter int unsigned RATE_BITS = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen_dec,
  input  logic        stn,
  input  logic [7:0]  phrase,
  output logic        busyn,
  output logic        ctrl_flush,
  output logic [16:0] ctrl_addr,
  output logic        ctrl_cs,
  input  logic [7:0]  ctrl_din,
  input  logic        ctrl_ok,
  output logic        ctrl_busyn,
  output logic        dec_rst,
  output logic        dec_en,
  output logic [3:0]  dec_din,
  output logic        silent
);

  typedef enum logic [2:0] {
    StIdle, StRdMax, StRdAh, StRdAl, StCmd, StCnt, StData, StSil
  } state_e;

  state_e               state_q, state_d;
  logic                 stn_q;
  logic [7:0]           phrase_q, phrase_d;
  logic [7:0]           ah_q, ah_d;
  logic                 cs_q, cs_d;
  logic                 flush_q, flush_d;
  logic [16:0]          addr_q, addr_d;
  logic                 busyn_q, busyn_d;
  logic                 cbusyn_q, cbusyn_d;
  logic                 dec_rst_q, dec_rst_d;
  logic                 dec_en_q, dec_en_d;
  logic [3:0]           dec_din_q, dec_din_d;
  logic                 silent_q, silent_d;
  logic [RATE_BITS-1:0] rate_q, rate_d;
  logic [RATE_BITS-1:0] div_q, div_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [8:0]           fetch_q, fetch_d;
  logic [10:0]          sil_q, sil_d;
  logic                 run_q, run_d;
  logic                 stall_q, stall_d;
  logic [7:0]           buf_q, buf_d;
  logic                 buf_v_q, buf_v_d;
  logic [3:0]           lo_q, lo_d;
  logic                 lo_v_q, lo_v_d;

  logic got;
  logic fire;
  logic emit;
  logic enter_data;

  assign got = cs_q & ctrl_ok;

  always_comb begin
    state_d    = state_q;
    phrase_d   = phrase_q;
    ah_d       = ah_q;
    cs_d       = 1'b0;
    flush_d    = 1'b0;
    addr_d     = addr_q;
    dec_rst_d  = 1'b0;
    dec_en_d   = 1'b0;
    dec_din_d  = dec_din_q;
    rate_d     = rate_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    fetch_d    = fetch_q;
    sil_d      = sil_q;
    run_d      = run_q;
    stall_d    = stall_q;
    buf_d      = buf_q;
    buf_v_d    = buf_v_q;
    lo_d       = lo_q;
    lo_v_d     = lo_v_q;
    fire       = 1'b0;
    emit       = 1'b0;
    enter_data = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (stn_q && !stn) begin
          phrase_d  = phrase;
          dec_rst_d = 1'b1;
          flush_d   = 1'b1;
          addr_d    = 17'd0;
          state_d   = StRdMax;
        end
      end
      StRdMax: begin
        cs_d = !got;
        if (got) begin
          if (phrase_q > ctrl_din) begin
            state_d = StIdle;
          end else begin
            flush_d = 1'b1;
            addr_d  = 17'd5 + {8'd0, phrase_q, 1'b0};
            state_d = StRdAh;
          end
        end
      end
      StRdAh: begin
        cs_d = !got;
        if (got) begin
          ah_d    = ctrl_din;
          state_d = StRdAl;
        end
      end
      StRdAl: begin
        cs_d = !got;
        if (got) begin
          flush_d = 1'b1;
          addr_d  = {ah_q, ctrl_din, 1'b0};
          state_d = StCmd;
        end
      end
      StCmd: begin
        cs_d = !got;
        if (got) begin
          unique case (ctrl_din[7:6])
            2'b00: begin
              if (ctrl_din[5:0] == 6'd0) begin
                state_d = StIdle;
              end else begin
                // (n+1)*32 pulses, counted down to zero inclusive
                sil_d   = {ctrl_din[5:0], 5'b11111};
                state_d = StSil;
              end
            end
            2'b01: begin
              rate_d     = RATE_BITS'(ctrl_din[5:0]);
              cnt_d      = 9'd256;
              fetch_d    = 9'd128;
              enter_data = 1'b1;
            end
            2'b10: begin
              rate_d  = RATE_BITS'(ctrl_din[5:0]);
              state_d = StCnt;
            end
            2'b11: state_d = StIdle;
          endcase
        end
      end
      StCnt: begin
        cs_d = !got;
        if (got) begin
          cnt_d      = {1'b0, ctrl_din} + 9'd1;
          fetch_d    = ({1'b0, ctrl_din} + 9'd2) >> 1;
          enter_data = 1'b1;
        end
      end
      StData: begin
        // Fetch only as many bytes as the nibble count needs, so the next
        // command byte is never consumed by the data path.
        cs_d = cs_q ? !ctrl_ok : ((fetch_q != 9'd0) && !buf_v_q);
        if (got) begin
          buf_d   = ctrl_din;
          buf_v_d = 1'b1;
          fetch_d = fetch_q - 9'd1;
          run_d   = 1'b1;
        end
        fire = run_q && (stall_q || (cen_dec && (div_q == rate_q)));
        if (fire) begin
          if (lo_v_q) begin
            emit      = 1'b1;
            dec_din_d = lo_q;
            lo_v_d    = 1'b0;
          end else if (buf_v_q) begin
            emit      = 1'b1;
            dec_din_d = buf_q[7:4];
            lo_d      = buf_q[3:0];
            lo_v_d    = 1'b1;
            buf_v_d   = 1'b0;
          end else begin
            stall_d = 1'b1;
          end
        end else if (run_q && cen_dec) begin
          div_d = div_q + RATE_BITS'(1);
        end
        if (emit) begin
          dec_en_d = 1'b1;
          div_d    = '0;
          stall_d  = 1'b0;
          cnt_d    = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = StCmd;
            run_d   = 1'b0;
            lo_v_d  = 1'b0;
          end
        end
      end
      StSil: begin
        if (cen_dec) begin
          if (sil_q == 11'd0) state_d = StCmd;
          else                sil_d   = sil_q - 11'd1;
        end
      end
    endcase

    if (enter_data) begin
      state_d = StData;
      run_d   = 1'b0;
      div_d   = '0;
      stall_d = 1'b0;
      buf_v_d = 1'b0;
      lo_v_d  = 1'b0;
    end

    busyn_d  = (state_d == StIdle) || (state_d == StRdMax);
    cbusyn_d = busyn_d | flush_d;
    silent_d = (state_d == StSil);
  end

  always_ff @(posedge clk) begin
    // Tracks stn even in reset so a level held low across release is no edge.
    stn_q <= stn;
    if (!rstn) begin
      state_q   <= StIdle;
      phrase_q  <= 8'd0;
      ah_q      <= 8'd0;
      cs_q      <= 1'b0;
      flush_q   <= 1'b0;
      addr_q    <= 17'd0;
      busyn_q   <= 1'b1;
      cbusyn_q  <= 1'b1;
      dec_rst_q <= 1'b0;
      dec_en_q  <= 1'b0;
      dec_din_q <= 4'd0;
      silent_q  <= 1'b0;
      rate_q    <= '0;
      div_q     <= '0;
      cnt_q     <= 9'd0;
      fetch_q   <= 9'd0;
      sil_q     <= 11'd0;
      run_q     <= 1'b0;
      stall_q   <= 1'b0;
      buf_q     <= 8'd0;
      buf_v_q   <= 1'b0;
      lo_q      <= 4'd0;
      lo_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phrase_q  <= phrase_d;
      ah_q      <= ah_d;
      cs_q      <= cs_d;
      flush_q   <= flush_d;
      addr_q    <= addr_d;
      busyn_q   <= busyn_d;
      cbusyn_q  <= cbusyn_d;
      dec_rst_q <= dec_rst_d;
      dec_en_q  <= dec_en_d;
      dec_din_q <= dec_din_d;
      silent_q  <= silent_d;
      rate_q    <= rate_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      fetch_q   <= fetch_d;
      sil_q     <= sil_d;
      run_q     <= run_d;
      stall_q   <= stall_d;
      buf_q     <= buf_d;
      buf_v_q   <= buf_v_d;
      lo_q      <= lo_d;
      lo_v_q    <= lo_v_d;
    end
  end

  assign busyn      = busyn_q;
  assign ctrl_flush = flush_q;
  assign ctrl_addr  = addr_q;
  assign ctrl_cs    = cs_q;
  assign ctrl_busyn = cbusyn_q;
  assign dec_rst    = dec_rst_q;
  assign dec_en     = dec_en_q;
  assign dec_din    = dec_din_q;
  assign silent     = silent_q;

endmodule

// File: tb/tb_jt7759_parser.sv
// Bench for jt7759_parser: ROM-backed data-stage model, table of playback scenarios,
// plus reset corner sequences.
module tb_jt7759_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cen_dec;
  logic        stn;
  logic [7:0]  phrase;
  logic        busyn;
  logic        ctrl_flush;
  logic [16:0] ctrl_addr;
  logic        ctrl_cs;
  logic [7:0]  ctrl_din;
  logic        ctrl_ok;
  logic        ctrl_busyn;
  logic        dec_rst;
  logic        dec_en;
  logic [3:0]  dec_din;
  logic        silent;

  always #5 clk = ~clk;

  jt7759_parser #(.RATE_BITS(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cen_dec    (cen_dec),
    .stn        (stn),
    .phrase     (phrase),
    .busyn      (busyn),
    .ctrl_flush (ctrl_flush),
    .ctrl_addr  (ctrl_addr),
    .ctrl_cs    (ctrl_cs),
    .ctrl_din   (ctrl_din),
    .ctrl_ok    (ctrl_ok),
    .ctrl_busyn (ctrl_busyn),
    .dec_rst    (dec_rst),
    .dec_en     (dec_en),
    .dec_din    (dec_din),
    .silent     (silent)
  );

  typedef struct {
    logic [7:0] phrase;
    int         ok_dly;
    int         nh;
    logic [7:0] h0;
    logic [7:0] h1;
    int         nd;
    bit         exp_busy;
    int         exp_flush;
    int         exp_nib;
    int         exp_gap;
    int         exp_sil;
  } vec_t;

  vec_t        vecs [7];
  logic [7:0]  rom [131072];
  logic [16:0] ptr;
  int          dly;
  int          ok_dly;
  int          cen_div;
  int          cen_cnt;
  int          flushes [$];
  logic [3:0]  nibs [$];
  int          nib_cen [$];
  int          sil_cnt, rst_cnt, overlap, en_sil;
  bit          busy_seen, prev_silent;
  int          n_chk, n_fail;

  function automatic logic [7:0] data_byte(input int k);
    return 8'hAB + 8'(k) * 8'h22;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic clear_logs();
    flushes.delete();
    nibs.delete();
    nib_cen.delete();
    sil_cnt = 0; rst_cnt = 0; overlap = 0; en_sil = 0; busy_seen = 1'b0;
  endtask

  task automatic wait_busyn(input logic lvl, input int max_cyc, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < max_cyc && !hit; c++) begin
      @(negedge clk);
      if (busyn == lvl) hit = 1'b1;
    end
  endtask

  task automatic load_rom(input vec_t v);
    for (int a = 0; a < 1024; a++) rom[17'(a)] = 8'h00;
    rom[0] = 8'h02;
    rom[7] = 8'h00; rom[8]  = 8'h10;
    rom[9] = 8'h00; rom[10] = 8'h10;
    rom[32] = v.h0;
    if (v.nh > 1) rom[33] = v.h1;
    for (int k = 0; k < v.nd; k++) rom[17'(32 + v.nh + k)] = data_byte(k);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    stn = 1'b0;
    repeat (3) @(negedge clk);
    stn = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busyn"}, int'(busyn), 1);
    chk({tag, " ctrl_busyn"}, int'(ctrl_busyn), 1);
    chk({tag, " ctrl_cs"}, int'(ctrl_cs), 0);
    chk({tag, " ctrl_flush"}, int'(ctrl_flush), 0);
    chk({tag, " ctrl_addr"}, int'(ctrl_addr), 0);
    chk({tag, " dec_en"}, int'(dec_en), 0);
    chk({tag, " dec_din"}, int'(dec_din), 0);
    chk({tag, " dec_rst"}, int'(dec_rst), 0);
    chk({tag, " silent"}, int'(silent), 0);
  endtask

  task automatic chk_run(input string tag, input vec_t v);
    int bad_nib, bad_gap, n;
    chk({tag, " flush count"}, flushes.size(), v.exp_flush);
    if (flushes.size() >= 1) chk({tag, " flush0 addr"}, flushes[0], 0);
    if (v.exp_flush == 3 && flushes.size() == 3) begin
      chk({tag, " flush1 addr"}, flushes[1], 5 + 2 * int'(v.phrase));
      chk({tag, " flush2 addr"}, flushes[2], 32);
    end
    chk({tag, " dec_rst pulses"}, rst_cnt, 1);
    chk({tag, " nibble count"}, nibs.size(), v.exp_nib);
    bad_nib = 0;
    n = (nibs.size() < v.exp_nib) ? nibs.size() : v.exp_nib;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      logic [3:0] e;
      b = data_byte(k / 2);
      e = (k % 2 == 0) ? b[7:4] : b[3:0];
      if (nibs[k] != e) bad_nib++;
    end
    chk({tag, " bad nibbles"}, bad_nib, 0);
    if (v.exp_gap != 0) begin
      bad_gap = 0;
      for (int k = 1; k < nib_cen.size(); k++)
        if (nib_cen[k] - nib_cen[k-1] != v.exp_gap) bad_gap++;
      chk({tag, " bad nibble spacing"}, bad_gap, 0);
    end
    chk({tag, " silent cen pulses"}, sil_cnt, v.exp_sil);
    chk({tag, " dec_en while silent"}, en_sil, 0);
    chk({tag, " busyn went low"}, int'(busy_seen), int'(v.exp_busy));
    chk({tag, " busyn at end"}, int'(busyn), 1);
    chk({tag, " ctrl_busyn at end"}, int'(ctrl_busyn), 1);
    chk({tag, " cs during flush"}, overlap, 0);
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    bit    hit;
    string tag;
    v   = vecs[i];
    tag = $sformatf("v%0d", i);
    load_rom(v);
    ok_dly = v.ok_dly;
    phrase = v.phrase;
    clear_logs();
    start_pulse();
    if (v.exp_busy) begin
      wait_busyn(1'b0, 400, hit);
      chk({tag, " busyn falls"}, int'(hit), 1);
      // a second start while playing must be ignored
      stn = 1'b0;
      repeat (2) @(negedge clk);
      stn = 1'b1;
      wait_busyn(1'b1, 30000, hit);
      chk({tag, " busyn returns"}, int'(hit), 1);
    end
    repeat (300) @(negedge clk);
    chk_run(tag, v);
  endtask

  // Output monitor plus data-stage model; one process keeps ordering deterministic.
  initial begin
    cen_dec = 1'b0; ctrl_ok = 1'b0; ctrl_din = 8'h00; ptr = 17'd0; dly = 0;
    cen_div = 0; cen_cnt = 0; prev_silent = 1'b0;
    forever begin
      @(negedge clk);
      if (cen_dec) cen_cnt++;
      if (prev_silent && cen_dec) sil_cnt++;
      prev_silent = silent;
      if (ctrl_flush) flushes.push_back(int'(ctrl_addr));
      if (dec_en) begin
        nibs.push_back(dec_din);
        nib_cen.push_back(cen_cnt);
        if (silent) en_sil++;
      end
      if (dec_rst) rst_cnt++;
      if (!busyn) busy_seen = 1'b1;
      if (ctrl_cs && ctrl_flush) overlap++;
      if (ctrl_flush) begin
        ptr = ctrl_addr; ctrl_ok = 1'b0; dly = 0;
      end else if (ctrl_cs) begin
        if (!ctrl_ok) begin
          if (dly >= ok_dly) begin
            ctrl_ok  = 1'b1;
            ctrl_din = rom[ptr];
          end else begin
            dly++;
          end
        end
      end else begin
        if (ctrl_ok) ptr = ptr + 17'd1;
        ctrl_ok = 1'b0;
        dly     = 0;
      end
      cen_div = (cen_div + 1) % 4;
      cen_dec = (cen_div == 0);
    end
  end

  initial begin
    bit hit;
    n_chk = 0; n_fail = 0; ok_dly = 0;
    rstn = 1'b0; stn = 1'b0; phrase = 8'd0;
    clear_logs();

    vecs[0] = '{8'd1, 0,  2, 8'h82, 8'h03, 2,   1'b1, 3, 4,   3, 0};
    vecs[1] = '{8'd3, 0,  1, 8'h00, 8'h00, 0,   1'b0, 1, 0,   0, 0};
    vecs[2] = '{8'd1, 0,  1, 8'h41, 8'h00, 128, 1'b1, 3, 256, 2, 0};
    vecs[3] = '{8'd1, 0,  2, 8'h01, 8'h00, 0,   1'b1, 3, 0,   0, 64};
    vecs[4] = '{8'd1, 20, 2, 8'h82, 8'h04, 3,   1'b1, 3, 5,   0, 0};
    vecs[5] = '{8'd2, 0,  2, 8'h80, 8'h00, 1,   1'b1, 3, 1,   0, 0};
    vecs[6] = '{8'd1, 0,  1, 8'hC5, 8'h00, 0,   1'b1, 3, 0,   0, 0};

    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");

    // stn low across reset release: no start without a fresh falling edge
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("stn held low flushes", flushes.size(), 0);
    chk("stn held low busyn", int'(busyn), 1);
    stn = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i);

    // reset in the middle of DATA, then a normal restart
    load_rom(vecs[2]);
    ok_dly = 0;
    phrase = vecs[2].phrase;
    clear_logs();
    start_pulse();
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      if (nibs.size() >= 10) hit = 1'b1;
    end
    chk("midreset reached DATA", int'(hit), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    clear_logs();
    start_pulse();
    wait_busyn(1'b0, 400, hit);
    chk("restart busyn falls", int'(hit), 1);
    wait_busyn(1'b1, 30000, hit);
    chk("restart busyn returns", int'(hit), 1);
    repeat (300) @(negedge clk);
    chk_run("restart", vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt7759_parser.md
JT7759_PARSER -- requirements
Module: jt7759_parser

Interface
REQ-001 SHALL have parameter RATE_BITS, default 6, width of the nibble-rate field.
REQ-002 SHALL have ports, with clock and reset first:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- cen_dec  in  1  decoder-rate clock enable.
- stn  in  1  start strobe, active low; a falling edge starts playback.
- phrase  in  8  sample number, latched on the stn falling edge.
- busyn  out  1  low while playing.
- ctrl_flush  out  1  one-cycle pulse; loads ctrl_addr into the data stage.
- ctrl_addr  out  17  byte address for the next flush.
- ctrl_cs  out  1  byte request; each rising edge requests one byte.
- ctrl_din  in  8  byte returned by the data stage.
- ctrl_ok  in  1  ctrl_din valid; held while ctrl_cs stays high.
- ctrl_busyn  out  1  low while the data stage may prefetch.
- dec_rst  out  1  one-cycle pulse; clears the ADPCM decoder state.
- dec_en  out  1  one-cycle pulse; dec_din is valid.
- dec_din  out  4  ADPCM nibble.
- silent  out  1  high during a silence command.

Function
REQ-003 SHALL latch phrase and leave IDLE only on a stn falling edge while in IDLE; stn edges in any other state SHALL be ignored.
REQ-004 SHALL run these states: IDLE, RD_MAX, RD_AH, RD_AL, CMD, CNT, DATA, SIL.
REQ-005 Byte read protocol:
- ctrl_cs SHALL rise the cycle after a state is entered (ctrl_cs low for at least 1 cycle between reads).
- The byte SHALL be captured on the first cycle with ctrl_cs & ctrl_ok.
- ctrl_cs SHALL drop the next cycle.
- ctrl_cs SHALL never be high in the same cycle as ctrl_flush.
REQ-006 Start sequence:
- Start SHALL pulse dec_rst and ctrl_flush with ctrl_addr=0, then enter RD_MAX.
- If phrase > byte read in RD_MAX: SHALL return to IDLE; busyn is not asserted.
- Otherwise: SHALL flush to 5+2*phrase and enter RD_AH.
REQ-007 RD_AH then RD_AL SHALL read the high and low address bytes, then flush to {AH,AL,1'b0} truncated to 17 bits, then enter CMD.
REQ-008 CMD byte decode:
- 00000000: end of sample; SHALL go to IDLE.
- 00nnnnnn: SIL for (n+1)*32 cen_dec pulses.
- 01rrrrrr: rate=r, count=256 nibbles, go to DATA.
- 10rrrrrr: rate=r, go to CNT.
- 11xxxxxx: treated as end; SHALL go to IDLE.
REQ-009 CNT SHALL read byte c and set count=c+1 nibbles (range 1..256), then enter DATA.
REQ-010 DATA behaviour:
- Reads one byte per two nibbles, high nibble first.
- One dec_en pulse every rate+1 cen_dec pulses; the first nibble comes rate+1 cen_dec pulses after the byte is captured.
- When count reaches 0: go to CMD; an unused low nibble of an odd count SHALL be discarded.
- If the next byte is not ready at a nibble slot, the slot SHALL stall (no dec_en) until ctrl_ok.
REQ-011 SIL SHALL hold silent=1, emit no dec_en, then return to CMD.
REQ-012 Output behaviour:
- busyn=0 from the RD_AH entry until the return to IDLE.
- ctrl_busyn SHALL equal busyn except it is forced 1 for the cycle of each ctrl_flush.
REQ-013 Counters SHALL be sized so no wrap occurs: count 9 bits, silence counter 11 bits, rate divider RATE_BITS bits.

Reset
REQ-014 With rstn=0 at a clk edge, the block SHALL enter IDLE and set these outputs:
- busyn=1, ctrl_busyn=1
- ctrl_cs=0, ctrl_flush=0, ctrl_addr=0
- dec_en=0, dec_din=0, dec_rst=0
- silent=0
REQ-015 Reset mid-playback SHALL abort on the same edge; the first stn falling edge after release SHALL start normally.
REQ-016 stn held low through reset release SHALL NOT start playback; a fresh falling edge is required.

Verification
REQ-017 ROM byte0=2, phrase=1, table bytes 7/8=0x00,0x10, data at 0x20 = 0x82,0x03,0xAB,0xCD,0x00 -> flushes to 0, 7, 0x20; dec_din sequence A,B,C,D, each 3 cen_dec apart; busyn returns to 1.
REQ-018 ROM byte0=2, phrase=3 -> a single flush to 0, then IDLE; busyn stays 1 and no dec_en pulses.
REQ-019 Command 0x41 followed by 128 bytes -> exactly 256 dec_en pulses, 2 cen_dec apart.
REQ-020 Command 0x01 then 0x00 -> silent=1 for exactly 64 cen_dec pulses, no dec_en, then end.
REQ-021 ctrl_ok delayed 20 cycles per byte -> dec_en stalls, no nibble is lost or duplicated, and ctrl_cs is low for at least 1 cycle between requests.
REQ-022 rstn low during DATA, then stn pulse -> outputs at reset values on the next edge, and playback restarts from a flush to 0.
